// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cnn_pkg
// Brief    : Shared types and constants for the CNN frame sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package cnn_pkg;

    localparam int DEF_NUM_LAYERS = 6;
    localparam int LYR_IDX_W      = 3;
    localparam int MAX_LAYERS     = 1 << LYR_IDX_W;
    localparam int FRM_CNT_W      = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LSTRT = 3'd1,
        ST_LWAIT = 3'd2,
        ST_TX    = 3'd3,
        ST_TXW   = 3'd4,
        ST_ERR   = 3'd5
    } sched_st_t;

    function automatic logic [MAX_LAYERS-1:0] idx_onehot(input logic [LYR_IDX_W-1:0] idx);
        logic [MAX_LAYERS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cnn_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : cnn_sched_if
// Brief    : Sequencer-to-pipeline handshake bundle (layers + UART).
// Revision : 1.0 - initial release
// ============================================================================
interface cnn_sched_if
    import cnn_pkg::*;
#(
    parameter int NUM_LAYERS = DEF_NUM_LAYERS
);

    logic                  strt;
    logic [NUM_LAYERS-1:0] lyr_done;
    logic                  tx_done;
    logic [NUM_LAYERS-1:0] lyr_strt;
    logic                  trmt;
    logic                  bsy;
    logic                  err;
    logic [LYR_IDX_W-1:0]  lyr_idx;
    logic [FRM_CNT_W-1:0]  frm_cnt;

    modport master (
        input  strt, lyr_done, tx_done,
        output lyr_strt, trmt, bsy, err, lyr_idx, frm_cnt
    );

    modport slave (
        output strt, lyr_done, tx_done,
        input  lyr_strt, trmt, bsy, err, lyr_idx, frm_cnt
    );

endinterface
`default_nettype wire

// File: rtl/wdog_cnt.sv
`default_nettype none
// ============================================================================
// Module   : wdog_cnt
// Brief    : Per-step watchdog; flags the waiting cycle that reaches all-ones.
// Revision : 1.0 - initial release
// ============================================================================
module wdog_cnt #(
    parameter int TMO_W = 20
) (
    input  wire  clk,
    input  wire  rst_n,
    input  wire  clr,
    input  wire  en,
    output logic tmo
);

    logic [TMO_W-1:0] r_cnt;
    logic [TMO_W-1:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + TMO_W'(1);
    // tmo marks the enabled cycle whose increment lands on all-ones, i.e.
    // the (2^TMO_W-1)-th waiting cycle since the last clear.
    assign tmo       = en & (&w_cnt_inc);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_cnt_inc;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cnn_sched.sv
`default_nettype none
// ============================================================================
// Module   : cnn_sched
// Brief    : Frame sequencer: starts each CNN layer in turn, then the UART.
// Revision : 1.0 - initial release
// ============================================================================
module cnn_sched
    import cnn_pkg::*;
#(
    parameter int NUM_LAYERS = DEF_NUM_LAYERS,
    parameter int TMO_W      = 20
) (
    input  wire          clk,
    input  wire          rst_n,
    cnn_sched_if.master  io_sched
);

    localparam logic [LYR_IDX_W-1:0] LAST_IDX = LYR_IDX_W'(NUM_LAYERS - 1);

    sched_st_t             r_state;
    sched_st_t             w_state_nxt;
    logic [LYR_IDX_W-1:0]  r_lyr_idx;
    logic [LYR_IDX_W-1:0]  w_lyr_idx_nxt;
    logic [FRM_CNT_W-1:0]  r_frm_cnt;
    logic [FRM_CNT_W-1:0]  w_frm_cnt_nxt;
    logic [NUM_LAYERS-1:0] r_lyr_strt;
    logic [NUM_LAYERS-1:0] w_lyr_strt_nxt;
    logic                  r_trmt;
    logic                  r_bsy;
    logic                  r_err;
    logic                  w_trmt_nxt;
    logic                  w_bsy_nxt;
    logic                  w_err_nxt;
    logic [MAX_LAYERS-1:0] w_done_vec;
    logic                  w_done;
    logic                  w_tmo;
    logic                  w_wd_clr;
    logic                  w_wd_en;

    assign w_done_vec = MAX_LAYERS'(io_sched.lyr_done);
    // Only the current layer's completion counts; other bits are ignored.
    assign w_done     = |(w_done_vec & idx_onehot(r_lyr_idx));
    assign w_wd_clr   = (r_state == ST_LSTRT) || (r_state == ST_TX);
    assign w_wd_en    = (r_state == ST_LWAIT) || (r_state == ST_TXW);

    wdog_cnt #(
        .TMO_W (TMO_W)
    ) u_wdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_wd_clr),
        .en    (w_wd_en),
        .tmo   (w_tmo)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_lyr_idx_nxt = r_lyr_idx;
        w_frm_cnt_nxt = r_frm_cnt;
        case (r_state)
            ST_IDLE, ST_ERR: begin
                if (io_sched.strt) begin
                    w_state_nxt   = ST_LSTRT;
                    w_lyr_idx_nxt = '0;
                end
            end
            ST_LSTRT: w_state_nxt = ST_LWAIT;
            ST_LWAIT: begin
                // Completion takes priority over a coincident terminal count.
                if (w_done) begin
                    if (r_lyr_idx == LAST_IDX) begin
                        w_state_nxt = ST_TX;
                    end else begin
                        w_state_nxt   = ST_LSTRT;
                        w_lyr_idx_nxt = r_lyr_idx + LYR_IDX_W'(1);
                    end
                end else if (w_tmo) begin
                    w_state_nxt = ST_ERR;
                end
            end
            ST_TX: w_state_nxt = ST_TXW;
            ST_TXW: begin
                if (io_sched.tx_done) begin
                    w_state_nxt   = ST_IDLE;
                    w_frm_cnt_nxt = r_frm_cnt + FRM_CNT_W'(1);
                end else if (w_tmo) begin
                    w_state_nxt = ST_ERR;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with it.
    always_comb begin
        w_lyr_strt_nxt = '0;
        if (w_state_nxt == ST_LSTRT) begin
            for (int k = 0; k < NUM_LAYERS; k++) begin
                w_lyr_strt_nxt[k] = (w_lyr_idx_nxt == LYR_IDX_W'(k));
            end
        end
        w_trmt_nxt = (w_state_nxt == ST_TX);
        w_err_nxt  = (w_state_nxt == ST_ERR);
        w_bsy_nxt  = (w_state_nxt == ST_LSTRT) || (w_state_nxt == ST_LWAIT) ||
                     (w_state_nxt == ST_TX)    || (w_state_nxt == ST_TXW);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_lyr_idx  <= '0;
            r_frm_cnt  <= '0;
            r_lyr_strt <= '0;
            r_trmt     <= 1'b0;
            r_bsy      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lyr_idx  <= w_lyr_idx_nxt;
            r_frm_cnt  <= w_frm_cnt_nxt;
            r_lyr_strt <= w_lyr_strt_nxt;
            r_trmt     <= w_trmt_nxt;
            r_bsy      <= w_bsy_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign io_sched.lyr_strt = r_lyr_strt;
    assign io_sched.trmt     = r_trmt;
    assign io_sched.bsy      = r_bsy;
    assign io_sched.err      = r_err;
    assign io_sched.lyr_idx  = r_lyr_idx;
    assign io_sched.frm_cnt  = r_frm_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cnn_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnn_sched
// Brief    : Randomized frame bench for cnn_sched with a schedule-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cnn_sched;

    localparam int N       = 6;
    localparam int TMO_W   = 4;
    localparam int TMO_CYC = (1 << TMO_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   m_frm  = 0;
    int   m_err  = 0;
    int   m_idx  = 0;
    int   g_bsy_len;

    cnn_sched_if #(.NUM_LAYERS(N)) u_if ();

    cnn_sched #(
        .NUM_LAYERS (N),
        .TMO_W      (TMO_W)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .io_sched (u_if.master)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_outs(input int e_strt, input int e_trmt, input int e_bsy,
                              input int e_err, input int e_idx, input int e_frm);
        check_val("lyr_strt", 32'(u_if.lyr_strt), 32'(e_strt));
        check_val("trmt",     32'(u_if.trmt),     32'(e_trmt));
        check_val("bsy",      32'(u_if.bsy),      32'(e_bsy));
        check_val("err",      32'(u_if.err),      32'(e_err));
        check_val("lyr_idx",  32'(u_if.lyr_idx),  32'(e_idx));
        check_val("frm_cnt",  32'(u_if.frm_cnt),  32'(e_frm));
    endtask

    // Idle/ERR cycles: all inputs but strt are don't-care and must be ignored.
    task automatic idle_cycles(input int n, input bit late_tx, input bit noise);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check_outs(0, 0, 0, m_err, m_idx, m_frm);
            u_if.strt     = 1'b0;
            u_if.lyr_done = noise ? N'($urandom) : '0;
            u_if.tx_done  = (late_tx && i == 0) || (noise && $urandom_range(0, 1) == 1);
        end
        u_if.lyr_done = '0;
        u_if.tx_done  = 1'b0;
    endtask

    // One frame. Offsets count cycles from the cycle in which strt is high.
    // hang: -1 none, 0..N-1 withhold that layer's done, N withhold tx_done.
    // flat/ftx: fixed layer/UART latency (0 = random). rst_tx: reset after
    // that many TXW cycles (0 = no reset).
    task automatic run_frame(input int hang, input int flat, input int ftx,
                             input bit noise, input int rst_tx);
        int lat[N];
        int s[N];
        int t, txl, last, n_st, e_strt, e_idx;
        bit is_err, tx_on;
        logic [N-1:0] v, msk;
        t = 0; txl = 0; last = 0; n_st = N; is_err = 0; tx_on = 0; e_idx = 0;
        g_bsy_len = 0;
        for (int k = 0; k < N; k++) begin
            lat[k] = (flat > 0) ? flat : int'($urandom_range(1, TMO_CYC));
            s[k]   = 0;
        end
        for (int k = 0; k < N; k++) begin
            s[k] = (k == 0) ? 1 : s[k-1] + lat[k-1] + 1;
            if (hang == k) begin
                n_st = k + 1; is_err = 1; last = s[k] + TMO_CYC;
                break;
            end
        end
        if (!is_err) begin
            tx_on = 1;
            t     = s[N-1] + lat[N-1] + 1;
            txl   = (ftx > 0) ? ftx : int'($urandom_range(1, TMO_CYC));
            if (rst_tx > 0) last = t + rst_tx;
            else if (hang == N) begin is_err = 1; last = t + TMO_CYC; end
            else last = t + txl;
        end
        for (int off = 0; off <= last + 1; off++) begin
            @(posedge clk); #1;
            if (u_if.bsy === 1'b1) g_bsy_len++;
            e_strt = 0;
            for (int k = 0; k < n_st; k++) begin
                if (s[k] == off) e_strt |= (1 << k);
                if (s[k] <= off) e_idx = k;
            end
            if (off == 0)          check_outs(0, 0, 0, m_err, m_idx, m_frm);
            else if (off <= last)  check_outs(e_strt, int'(tx_on && off == t), 1, 0, e_idx, m_frm);
            else if (rst_tx > 0)   check_outs(0, 0, 0, 0, 0, 0);
            else if (is_err)       check_outs(0, 0, 0, 1, e_idx, m_frm);
            else                   check_outs(0, 0, 0, 0, e_idx, (m_frm + 1) % 256);
            v = '0; msk = '1;
            if (off <= last) begin
                for (int k = 0; k < n_st; k++) begin
                    if (k != hang && off == s[k] + lat[k]) v[k] = 1'b1;
                    if (off > s[k] && (k == hang || off <= s[k] + lat[k])) msk[k] = 1'b0;
                end
                if (noise && off >= 1 && $urandom_range(0, 3) == 0) v |= N'($urandom) & msk;
            end
            u_if.lyr_done = v;
            u_if.strt     = (off == 0) || (noise && off >= 1 && off <= last && $urandom_range(0, 7) == 0);
            u_if.tx_done  = (tx_on && rst_tx == 0 && hang != N && off == t + txl) ||
                            (noise && off >= 1 && off <= t && $urandom_range(0, 5) == 0);
            rst_n         = !(rst_tx > 0 && off == last);
        end
        check_val("bsy_len", 32'(g_bsy_len), 32'(last));
        if (rst_tx > 0) begin
            m_frm = 0; m_err = 0; m_idx = 0;
        end else if (is_err) begin
            m_err = 1; m_idx = e_idx;
        end else begin
            m_frm = (m_frm + 1) % 256; m_err = 0; m_idx = N - 1;
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        u_if.strt     = 1'b0;
        u_if.lyr_done = '0;
        u_if.tx_done  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outs(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        idle_cycles(2, 1'b0, 1'b1);

        // nominal frame: 3-cycle layers, 5-cycle UART
        run_frame(-1, 3, 5, 1'b0, 0);
        check_val("nominal_bsy_len", 32'(g_bsy_len), 32'(6 * 4 + 6));
        idle_cycles(2, 1'b0, 1'b0);

        // shortest possible frame
        run_frame(-1, 1, 1, 1'b0, 0);
        check_val("min_bsy_len", 32'(g_bsy_len), 32'(2 * N + 2));

        // wrong-layer dones, stray strt/tx_done
        for (int i = 0; i < 4; i++) begin
            run_frame(-1, 0, 0, 1'b1, 0);
            idle_cycles(int'($urandom_range(0, 2)), 1'b0, 1'b1);
        end

        // watchdog on layer 2, sticky through idle, then restart
        run_frame(2, 0, 0, 1'b1, 0);
        idle_cycles(3, 1'b0, 1'b1);
        run_frame(-1, 0, 0, 1'b0, 0);

        // completion coincident with terminal count
        run_frame(-1, TMO_CYC, TMO_CYC, 1'b0, 0);

        // UART hang, immediate restart from ERR
        run_frame(N, 0, 0, 1'b1, 0);
        run_frame(-1, 0, 0, 1'b1, 0);

        // reset during TXW, then a late tx_done
        run_frame(-1, 0, 0, 1'b1, 3);
        idle_cycles(3, 1'b1, 1'b0);

        // frame counter wrap
        for (int i = 0; i < 260; i++) begin
            run_frame(-1, 1, 1, (i % 4) == 0, 0);
            if ((i % 8) == 0) idle_cycles(1, 1'b0, 1'b0);
        end

        // random mix including hangs
        for (int i = 0; i < 20; i++) begin
            run_frame(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N)) : -1,
                      0, 0, 1'b1, 0);
            idle_cycles(int'($urandom_range(0, 2)), 1'b0, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
